game_state_ctrl: RTL and testbench

Parametrised Pac-Man game-flow controller replacing the inline top-level state machine. Takes Pac-Man and N ghost tile coordinates plus the remaining-pill count. Owns lives, level, death/resume delay, level-clear delay, pause and game-over sequencing. Drives sprite/map reset and ghost enable to the location controllers, map RAM writer and HEX displays.

---
 rtl/pacman_pkg.sv | 25 ++
 rtl/game_delay_timer.sv | 28 ++
 rtl/game_state_ctrl.sv | 157 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared game-flow state encoding, tile widths and tile-match helper
package pacman_pkg;

  localparam int TILE_X_W = 6;
  localparam int TILE_Y_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PLAY        = 3'd1,
    ST_PAUSE       = 3'd2,
    ST_DYING       = 3'd3,
    ST_LEVEL_CLEAR = 3'd4,
    ST_OVER        = 3'd5
  } game_state_e;

  function automatic logic tile_match(
    input logic [TILE_X_W-1:0] ax,
    input logic [TILE_Y_W-1:0] ay,
    input logic [TILE_X_W-1:0] bx,
    input logic [TILE_Y_W-1:0] by
  );
    return (ax == bx) && (ay == by);
  endfunction

endpackage

// File: rtl/game_delay_timer.sv
// rtl/game_delay_timer.sv - loadable down-counter; done while the count sits at zero
module game_delay_timer
  import pacman_pkg::*;
#(
  parameter int W = 28
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - Pac-Man game-flow controller: lives, level, delays, pause, game over
// Optional GAME_PAUSE_EN builds the PAUSE state and pause_req edge detector.
module game_state_ctrl
  import pacman_pkg::*;
#(
  parameter int NUM_GHOSTS    = 2,
  parameter int START_LIVES   = 3,
  parameter int RESUME_CYCLES = 250_000_000,
  parameter int CLEAR_CYCLES  = 100_000_000,
  parameter int PILL_W        = 10,
  parameter int LEVEL_W       = 4
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pause_req,
  input  logic [TILE_X_W-1:0]            pac_x,
  input  logic [TILE_Y_W-1:0]            pac_y,
  input  logic [TILE_X_W*NUM_GHOSTS-1:0] ghost_x,
  input  logic [TILE_Y_W*NUM_GHOSTS-1:0] ghost_y,
  input  logic [NUM_GHOSTS-1:0]          ghost_fright,
  input  logic [PILL_W-1:0]              pills_left,
  output logic [2:0]                     state,
  output logic                           sprite_reset,
  output logic                           map_reset,
  output logic                           ghost_enable,
  output logic                           input_enable,
  output logic [2:0]                     lives,
  output logic [LEVEL_W-1:0]             level,
  output logic                           death_pulse,
  output logic [NUM_GHOSTS-1:0]          ghost_eaten
);

  localparam int MAX_DELAY = (RESUME_CYCLES > CLEAR_CYCLES) ? RESUME_CYCLES : CLEAR_CYCLES;
  localparam int TIMER_W   = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [TIMER_W-1:0] RESUME_LOAD = TIMER_W'(RESUME_CYCLES - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LOAD  = TIMER_W'(CLEAR_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX   = {LEVEL_W{1'b1}};

  game_state_e            state_q, state_next;
  logic [2:0]             lives_q;
  logic [LEVEL_W-1:0]     level_q;
  logic                   play_entry_q;
  logic [NUM_GHOSTS-1:0]  match, lethal, edible, edible_q;
  logic                   any_lethal;
  logic                   pause_edge;
  logic                   timer_load, timer_done;
  logic [TIMER_W-1:0]     timer_val;

`ifdef GAME_PAUSE_EN
  logic pause_q;
  always_ff @(posedge CLOCK_50) begin
    if (reset) pause_q <= 1'b0;
    else       pause_q <= pause_req;
  end
  assign pause_edge = pause_req & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = pause_req;
  assign pause_edge   = 1'b0;
`endif

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      match[i] = tile_match(pac_x, pac_y,
                            ghost_x[TILE_X_W*i +: TILE_X_W],
                            ghost_y[TILE_Y_W*i +: TILE_Y_W]);
    end
  end

  assign lethal     = match & ~ghost_fright;
  assign edible     = match & ghost_fright;
  assign any_lethal = |lethal;

  always_comb begin
    state_next = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      ST_IDLE:        if (start) state_next = ST_PLAY;
      ST_PLAY: begin
        if (any_lethal)                              state_next = (lives_q > 3'd1) ? ST_DYING : ST_OVER;
        else if (pills_left == '0 && !play_entry_q)  state_next = ST_LEVEL_CLEAR;
        else if (pause_edge)                         state_next = ST_PAUSE;
      end
      ST_PAUSE:       if (pause_edge) state_next = ST_PLAY;
      ST_DYING:       if (timer_done) state_next = ST_PLAY;
      ST_LEVEL_CLEAR: if (timer_done) state_next = ST_PLAY;
      ST_OVER:        if (!start)     state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
    // Timer is armed on the cycle a delay state is entered so it expires exactly on time.
    if (state_next != state_q) begin
      if (state_next == ST_DYING) begin
        timer_load = 1'b1;
        timer_val  = RESUME_LOAD;
      end else if (state_next == ST_LEVEL_CLEAR) begin
        timer_load = 1'b1;
        timer_val  = CLEAR_LOAD;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lives_q      <= 3'(START_LIVES);
      level_q      <= LEVEL_W'(1);
      play_entry_q <= 1'b0;
      edible_q     <= '0;
      death_pulse  <= 1'b0;
      ghost_eaten  <= '0;
    end else begin
      state_q      <= state_next;
      // Upstream pill count reloads a cycle late after any entry into PLAY.
      play_entry_q <= (state_next == ST_PLAY) && (state_q != ST_PLAY);
      edible_q     <= edible;
      death_pulse  <= (state_q == ST_PLAY) && any_lethal;
      ghost_eaten  <= (state_q == ST_PLAY && !any_lethal) ? (edible & ~edible_q) : '0;
      if (state_q == ST_IDLE && state_next == ST_PLAY) begin
        lives_q <= 3'(START_LIVES);
        level_q <= LEVEL_W'(1);
      end
      if (state_q == ST_PLAY && any_lethal) lives_q <= lives_q - 3'd1;
      if (state_q == ST_LEVEL_CLEAR && state_next == ST_PLAY && level_q != LEVEL_MAX)
        level_q <= level_q + 1'b1;
    end
  end

  game_delay_timer #(.W(TIMER_W)) u_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_comb begin
    sprite_reset = 1'b0;
    map_reset    = 1'b0;
    ghost_enable = 1'b0;
    input_enable = 1'b0;
    case (state_q)
      ST_IDLE:        begin sprite_reset = 1'b1; map_reset = 1'b1; end
      ST_PLAY:        begin ghost_enable = 1'b1; input_enable = 1'b1; end
      ST_DYING:       sprite_reset = 1'b1;
      ST_LEVEL_CLEAR: begin sprite_reset = 1'b1; map_reset = 1'b1; end
      default:        ;
    endcase
  end

  assign state = state_q;
  assign lives = lives_q;
  assign level = level_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed self-checking bench for game_state_ctrl (GAME_PAUSE_EN aware)
module tb_game_state_ctrl;

  localparam int NG = 2;

  logic          CLOCK_50 = 1'b0;
  logic          reset, start, pause_req;
  logic [5:0]    pac_x;
  logic [4:0]    pac_y;
  logic [6*NG-1:0] ghost_x;
  logic [5*NG-1:0] ghost_y;
  logic [NG-1:0] ghost_fright;
  logic [9:0]    pills_left;
  logic [2:0]    state;
  logic          sprite_reset, map_reset, ghost_enable, input_enable;
  logic [2:0]    lives;
  logic [3:0]    level;
  logic          death_pulse;
  logic [NG-1:0] ghost_eaten;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  game_state_ctrl #(
    .NUM_GHOSTS(NG), .START_LIVES(3), .RESUME_CYCLES(10), .CLEAR_CYCLES(6),
    .PILL_W(10), .LEVEL_W(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .pause_req(pause_req),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .ghost_fright(ghost_fright), .pills_left(pills_left), .state(state),
    .sprite_reset(sprite_reset), .map_reset(map_reset), .ghost_enable(ghost_enable),
    .input_enable(input_enable), .lives(lives), .level(level),
    .death_pulse(death_pulse), .ghost_eaten(ghost_eaten)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic place_ghost(input int i, input logic [5:0] x, input logic [4:0] y);
    ghost_x[6*i +: 6] = x;
    ghost_y[5*i +: 5] = y;
  endtask

  task automatic check_decode(input string tag, input logic [2:0] st,
                              input logic sr, input logic mr, input logic ge, input logic ie);
    check({tag, ".state"}, state, st);
    check({tag, ".sprite_reset"}, sprite_reset, sr);
    check({tag, ".map_reset"}, map_reset, mr);
    check({tag, ".ghost_enable"}, ghost_enable, ge);
    check({tag, ".input_enable"}, input_enable, ie);
  endtask

  task automatic do_clear(input string tag);
    bit seen = 0;
    pills_left = 10'd0;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick();
      if (state == 3'd4) seen = 1;
    end
    check({tag, ".entered"}, seen, 1'b1);
    pills_left = 10'd100;
    for (int k = 0; k < 6; k++) tick();
  endtask

  initial begin
    int pulses;
    logic [NG-1:0] last_eaten;

    reset = 1'b1; start = 1'b0; pause_req = 1'b0;
    pac_x = 6'd5; pac_y = 5'd5;
    ghost_x = '0; ghost_y = '0;
    place_ghost(0, 6'd10, 5'd10);
    place_ghost(1, 6'd20, 5'd20);
    ghost_fright = '0; pills_left = 10'd100;
    tick(); tick();
    reset = 1'b0;
    check_decode("reset", 3'd0, 1, 1, 0, 0);
    check("reset.lives", lives, 3);
    check("reset.level", level, 1);
    check("reset.death_pulse", death_pulse, 0);
    check("reset.ghost_eaten", ghost_eaten, 0);

    start = 1'b1;
    tick();
    check_decode("start", 3'd1, 0, 0, 1, 1);
    check("start.lives", lives, 3);
    check("start.level", level, 1);

    // Lethal ghost0 sampled at t
    place_ghost(0, 6'd5, 5'd5);
    tick();
    place_ghost(0, 6'd10, 5'd10);
    check_decode("die.t1", 3'd3, 1, 0, 0, 0);
    check("die.lives", lives, 2);
    check("die.pulse_t1", death_pulse, 1);
    tick();
    check("die.pulse_t2", death_pulse, 0);
    for (int k = 3; k <= 10; k++) tick();
    check("die.t10_state", state, 3);
    tick();
    check("die.t11_state", state, 1);

    // Edible ghost1 held on pac tile for 5 cycles
    ghost_fright = 2'b10;
    place_ghost(1, 6'd5, 5'd5);
    pulses = 0; last_eaten = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) check("eat.first", ghost_eaten, 2'b10);
      if (ghost_eaten != '0) begin pulses++; last_eaten = ghost_eaten; end
    end
    check("eat.pulses", pulses, 1);
    check("eat.value", last_eaten, 2'b10);
    check("eat.state", state, 1);
    check("eat.lives", lives, 2);
    place_ghost(1, 6'd20, 5'd20);
    ghost_fright = '0;
    tick();

    // Lethal and pills_left=0 together: death wins
    place_ghost(0, 6'd5, 5'd5);
    pills_left = 10'd0;
    tick();
    place_ghost(0, 6'd10, 5'd10);
    pills_left = 10'd100;
    check("prio.state", state, 3);
    check("prio.lives", lives, 1);
    for (int k = 2; k <= 11; k++) tick();
    check("prio.resume", state, 1);

    // First PLAY cycle after entry ignores pills_left=0
    pills_left = 10'd0;
    tick();
    check("clear.first_ignored", state, 1);
    tick();
    check_decode("clear.enter", 3'd4, 1, 1, 0, 0);
    pills_left = 10'd100;
    for (int k = 2; k <= 6; k++) tick();
    check("clear.t6_state", state, 4);
    tick();
    check("clear.exit_state", state, 1);
    check("clear.level", level, 2);

    // Last life lost -> OVER
    place_ghost(0, 6'd5, 5'd5);
    tick();
    place_ghost(0, 6'd10, 5'd10);
    check_decode("over", 3'd5, 0, 0, 0, 0);
    check("over.lives", lives, 0);
    check("over.pulse", death_pulse, 1);
    tick();
    check("over.hold", state, 5);
    start = 1'b0;
    tick();
    check("over.idle", state, 0);
    start = 1'b1;
    tick();
    check("restart.state", state, 1);
    check("restart.lives", lives, 3);
    check("restart.level", level, 1);

    // Pause edges
    tick();
    pause_req = 1'b1;
    tick();
`ifdef GAME_PAUSE_EN
    check_decode("pause", 3'd2, 0, 0, 0, 0);
    place_ghost(0, 6'd5, 5'd5);
    tick(); tick();
    check("pause.frozen", state, 2);
    check("pause.lives", lives, 3);
    check("pause.no_death", death_pulse, 0);
    place_ghost(0, 6'd10, 5'd10);
    pause_req = 1'b0;
    tick();
    pause_req = 1'b1;
    tick();
    check("pause.resume", state, 1);
`else
    check("nopause.edge1", state, 1);
    pause_req = 1'b0;
    tick();
    pause_req = 1'b1;
    tick();
    check("nopause.edge2", state, 1);
`endif
    pause_req = 1'b0;
    tick();

    // Level saturation at 15
    for (int n = 0; n < 15; n++) do_clear("sat");
    check("sat.level", level, 15);
    check("sat.state", state, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
